// File: rtl/coord_bcd_converter.sv
// Converts the x/y best-match coordinates to packed BCD with one shared double-dabble sequencer.
// Define COORD_BCD_SAT_EN to show all nines on overflow instead of the value modulo 10^DIGITS.
module coord_bcd_converter #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 4
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic [31:0]           x_in,
   input  logic [31:0]           y_in,
   output logic [4*DIGITS-1:0]   bcd_x,
   output logic [4*DIGITS-1:0]   bcd_y,
   output logic                  ovf_x,
   output logic                  ovf_y,
   output logic                  busy,
   output logic                  upd
);

   // One spare nibble above the displayed digits catches values >= 10^DIGITS.
   localparam int SW = 4 * (DIGITS + 1);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0]    cap_x_q, cap_x_d, cap_y_q, cap_y_d;
   logic [WIDTH-1:0]    bin_x_q, bin_x_d, bin_y_q, bin_y_d;
   logic [SW-1:0]       scr_x_q, scr_x_d, scr_y_q, scr_y_d;
   logic [SW-1:0]       scr_x_adj, scr_y_adj;
   logic [4*DIGITS-1:0] bcd_x_q, bcd_x_d, bcd_y_q, bcd_y_d;
   logic [4*DIGITS-1:0] disp_x, disp_y;
   logic                ovf_x_q, ovf_x_d, ovf_y_q, ovf_y_d;
   logic                top_x_nz, top_y_nz;
   logic                upd_q, upd_d;
   logic                input_changed;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS + 1; gi++) begin : g_add3
         assign scr_x_adj[4*gi +: 4] = (scr_x_q[4*gi +: 4] >= 4'd5) ? scr_x_q[4*gi +: 4] + 4'd3
                                                                   : scr_x_q[4*gi +: 4];
         assign scr_y_adj[4*gi +: 4] = (scr_y_q[4*gi +: 4] >= 4'd5) ? scr_y_q[4*gi +: 4] + 4'd3
                                                                   : scr_y_q[4*gi +: 4];
      end
      if (WIDTH < 32) begin : g_upper
         logic unused_upper;
         assign unused_upper = ^{x_in[31:WIDTH], y_in[31:WIDTH]};
      end
   endgenerate

   assign top_x_nz = (scr_x_q[SW-1 -: 4] != 4'd0);
   assign top_y_nz = (scr_y_q[SW-1 -: 4] != 4'd0);

`ifdef COORD_BCD_SAT_EN
   assign disp_x = top_x_nz ? {DIGITS{4'h9}} : scr_x_q[4*DIGITS-1:0];
   assign disp_y = top_y_nz ? {DIGITS{4'h9}} : scr_y_q[4*DIGITS-1:0];
`else
   assign disp_x = scr_x_q[4*DIGITS-1:0];
   assign disp_y = scr_y_q[4*DIGITS-1:0];
`endif

   assign input_changed = (x_in[WIDTH-1:0] != cap_x_q) || (y_in[WIDTH-1:0] != cap_y_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap_x_d = cap_x_q;
      cap_y_d = cap_y_q;
      bin_x_d = bin_x_q;
      bin_y_d = bin_y_q;
      scr_x_d = scr_x_q;
      scr_y_d = scr_y_q;
      bcd_x_d = bcd_x_q;
      bcd_y_d = bcd_y_q;
      ovf_x_d = ovf_x_q;
      ovf_y_d = ovf_y_q;
      upd_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (input_changed) begin
               cap_x_d = x_in[WIDTH-1:0];
               cap_y_d = y_in[WIDTH-1:0];
               bin_x_d = x_in[WIDTH-1:0];
               bin_y_d = y_in[WIDTH-1:0];
               scr_x_d = '0;
               scr_y_d = '0;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            {scr_x_d, bin_x_d} = {scr_x_adj[SW-2:0], bin_x_q, 1'b0};
            {scr_y_d, bin_y_d} = {scr_y_adj[SW-2:0], bin_y_q, 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_SHIFT) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            bcd_x_d = disp_x;
            bcd_y_d = disp_y;
            ovf_x_d = top_x_nz;
            ovf_y_d = top_y_nz;
            upd_d   = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cap_x_q <= '0;
         cap_y_q <= '0;
         bin_x_q <= '0;
         bin_y_q <= '0;
         scr_x_q <= '0;
         scr_y_q <= '0;
         bcd_x_q <= '0;
         bcd_y_q <= '0;
         ovf_x_q <= 1'b0;
         ovf_y_q <= 1'b0;
         upd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cap_x_q <= cap_x_d;
         cap_y_q <= cap_y_d;
         bin_x_q <= bin_x_d;
         bin_y_q <= bin_y_d;
         scr_x_q <= scr_x_d;
         scr_y_q <= scr_y_d;
         bcd_x_q <= bcd_x_d;
         bcd_y_q <= bcd_y_d;
         ovf_x_q <= ovf_x_d;
         ovf_y_q <= ovf_y_d;
         upd_q   <= upd_d;
      end
   end

   assign bcd_x = bcd_x_q;
   assign bcd_y = bcd_y_q;
   assign ovf_x = ovf_x_q;
   assign ovf_y = ovf_y_q;
   assign upd   = upd_q;
   assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_coord_bcd_converter.sv
// Scoreboard bench for coord_bcd_converter: directed coordinates with hand-computed BCD results.
module tb_coord_bcd_converter;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [31:0] x_in, y_in;
   logic [15:0] bcd_x, bcd_y;
   logic        ovf_x, ovf_y, busy, upd;

   typedef struct packed {
      logic [15:0] bx;
      logic [15:0] by;
      logic        ox;
      logic        oy;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   coord_bcd_converter #(.WIDTH(16), .DIGITS(4)) dut (
      .Clk(Clk), .Rst(Rst), .x_in(x_in), .y_in(y_in),
      .bcd_x(bcd_x), .bcd_y(bcd_y), .ovf_x(ovf_x), .ovf_y(ovf_y),
      .busy(busy), .upd(upd)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every upd pulse consumes one scoreboard entry; outputs may only move with upd.
   logic [33:0] prev_out = '0;
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         if (upd) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_upd: got bcd_x=%h bcd_y=%h expected no update", bcd_x, bcd_y);
            end else begin
               e = sb_q.pop_front();
               check("bcd_x", {16'd0, bcd_x}, {16'd0, e.bx});
               check("bcd_y", {16'd0, bcd_y}, {16'd0, e.by});
               check("ovf_x", {31'd0, ovf_x}, {31'd0, e.ox});
               check("ovf_y", {31'd0, ovf_y}, {31'd0, e.oy});
               $display("upd: bcd_x=%h bcd_y=%h ovf_x=%b ovf_y=%b", bcd_x, bcd_y, ovf_x, ovf_y);
            end
         end else if (!Rst && ({bcd_x, bcd_y, ovf_x, ovf_y} != prev_out)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL output_changed_without_upd: got %h expected %h", {bcd_x, bcd_y, ovf_x, ovf_y}, prev_out);
         end
         prev_out = {bcd_x, bcd_y, ovf_x, ovf_y};
      end
   end

   // Waits for an upd pulse; cycles counts negedges from the call, busy_n counts busy samples.
   task automatic wait_upd(input string name, input int exp_cycles, input int exp_busy);
      int cycles = 0;
      int busy_n = 0;
      bit seen = 0;
      while (!seen && cycles < 100) begin
         @(negedge Clk);
         cycles++;
         if (busy) busy_n++;
         if (upd) seen = 1;
      end
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: got no upd in %0d cycles expected upd", name, cycles);
      end else begin
         if (exp_cycles > 0) check({name, "_latency"}, cycles, exp_cycles);
         if (exp_busy > 0)   check({name, "_busy_cycles"}, busy_n, exp_busy);
         @(negedge Clk);
         check({name, "_upd_one_cycle"}, {31'd0, upd}, 32'd0);
      end
   endtask

   task automatic set_xy(input logic [31:0] x, input logic [31:0] y);
      @(posedge Clk);
      #1;
      x_in = x;
      y_in = y;
   endtask

   task automatic idle_check(input string name, input int n);
      int busy_n = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge Clk);
         if (busy) busy_n++;
      end
      check(name, busy_n, 0);
   endtask

`ifdef COORD_BCD_SAT_EN
   localparam logic [15:0] OVF_DISP_X = 16'h9999;
   localparam logic [15:0] OVF_DISP_Y = 16'h9999;
`else
   localparam logic [15:0] OVF_DISP_X = 16'h5535;
   localparam logic [15:0] OVF_DISP_Y = 16'h0000;
`endif

   initial begin
      Rst  = 1'b1;
      x_in = 32'd0;
      y_in = 32'd0;
      repeat (3) @(negedge Clk);
      check("rst_bcd_x", {16'd0, bcd_x}, 32'd0);
      check("rst_bcd_y", {16'd0, bcd_y}, 32'd0);
      check("rst_ovf", {30'd0, ovf_x, ovf_y}, 32'd0);
      check("rst_busy_upd", {30'd0, busy, upd}, 32'd0);
      @(posedge Clk);
      #1 Rst = 1'b0;
      idle_check("zero_inputs_no_conversion", 25);

      // 1234 / 56 from idle: 17 busy cycles, upd after the 18th edge.
      set_xy(32'd1234, 32'd56);
      sb_q.push_back('{16'h1234, 16'h0056, 1'b0, 1'b0});
      wait_upd("conv_1234_56", 19, 17);
      idle_check("held_inputs_no_conversion", 25);

      set_xy(32'd65535, 32'd56);
      sb_q.push_back('{OVF_DISP_X, 16'h0056, 1'b1, 1'b0});
      wait_upd("conv_65535", 19, 17);

      set_xy(32'd9999, 32'd10000);
      sb_q.push_back('{16'h9999, OVF_DISP_Y, 1'b0, 1'b1});
      wait_upd("conv_9999_10000", 19, 17);

      // Change mid-flight: the old value completes, then the new one converts.
      set_xy(32'd10, 32'd0);
      sb_q.push_back('{16'h0010, 16'h0000, 1'b0, 1'b0});
      sb_q.push_back('{16'h0020, 16'h0000, 1'b0, 1'b0});
      repeat (6) @(posedge Clk);
      #1 x_in = 32'd20;
      wait_upd("conv_10_inflight", 0, 0);
      wait_upd("conv_20_followup", 0, 0);

      // Abort with reset during SHIFT, then reconvert after release.
      set_xy(32'd999, 32'd0);
      repeat (9) @(posedge Clk);
      #1 Rst = 1'b1;
      #1;
      check("abort_bcd_x", {16'd0, bcd_x}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      repeat (2) @(posedge Clk);
      #1 Rst = 1'b0;
      sb_q.push_back('{16'h0999, 16'h0000, 1'b0, 1'b0});
      wait_upd("conv_999_after_rst", 19, 17);

      set_xy(32'h0001_0007, 32'hFFFF_0003);
      sb_q.push_back('{16'h0007, 16'h0003, 1'b0, 1'b0});
      wait_upd("conv_upper_ignored", 19, 17);
      set_xy(32'h0002_0007, 32'h0000_0003);
      idle_check("upper_bits_change_no_conversion", 25);

      check("scoreboard_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
